// File: rtl/boot_pkg.sv
// Shared types and helpers for the boot loader: FSM state encoding and
// modular checksum arithmetic.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_LOAD_ACC = 3'd0,
    ST_LOAD_WR  = 3'd1,
    ST_CSUM     = 3'd2,
    ST_VERIFY   = 3'd3,
    ST_CHECK    = 3'd4,
    ST_RUN      = 3'd5,
    ST_ERROR    = 3'd6
  } boot_state_t;

  // Widest word the checksum helper handles; callers truncate the result.
  localparam int unsigned CSUM_MAX_W = 64;

  function automatic logic [CSUM_MAX_W-1:0] csum_add(
    input logic [CSUM_MAX_W-1:0] sum,
    input logic [CSUM_MAX_W-1:0] word,
    input int unsigned           width
  );
    logic [CSUM_MAX_W-1:0] mask;
    mask = (width >= CSUM_MAX_W) ? '1
         : ((CSUM_MAX_W'(1) << width) - CSUM_MAX_W'(1));
    return (sum + word) & mask;
  endfunction

endpackage

// File: rtl/boot_rd_pipe.sv
// Valid-bit delay line matching the BSRAM read latency, so a read-back
// sample is taken exactly when mem_dout holds the addressed word.
module boot_rd_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue,
  output logic sample_vld
);

  logic [RD_LAT-1:0] vld_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
    end
  end

  assign sample_vld = vld_sr[RD_LAT-1];

endmodule

// File: rtl/boot_loader.sv
// Streams a program image into single-port BSRAM, verifies it by read-back
// against a trailing checksum, then hands the memory address to the CPU.
module boot_loader #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 11,
  parameter int PROG_LEN = 18,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_req,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              mem_ce,
  output logic              mem_wre,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              boot_mode,
  output logic              boot_done,
  output logic              boot_err,
  output logic [ADDR_W:0]   word_count
);

  import boot_pkg::*;

  if (PROG_LEN < 1 || PROG_LEN > (1 << ADDR_W)) begin : g_bad_prog_len
    $error("boot_loader: PROG_LEN must be in 1..2**ADDR_W");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
    $error("boot_loader: RD_LAT must be in 1..3");
  end
  if (DATA_W < 1 || DATA_W > int'(CSUM_MAX_W)) begin : g_bad_data_w
    $error("boot_loader: DATA_W exceeds checksum helper width");
  end

  localparam logic [ADDR_W:0]   PROG_LEN_CNT = (ADDR_W+1)'(PROG_LEN);
  localparam logic [ADDR_W:0]   CNT_ONE      = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(PROG_LEN - 1);

  function automatic logic [DATA_W-1:0] sum_next(
    input logic [DATA_W-1:0] sum,
    input logic [DATA_W-1:0] word
  );
    return DATA_W'(csum_add(CSUM_MAX_W'(sum), CSUM_MAX_W'(word), DATA_W));
  endfunction

  boot_state_t       state;
  logic [ADDR_W-1:0] boot_addr;
  logic [DATA_W-1:0] write_sum;
  logic [DATA_W-1:0] read_sum;
  logic [DATA_W-1:0] expected;
  logic [ADDR_W:0]   rd_issued;
  logic [ADDR_W:0]   rd_sampled;
  logic              rd_issue;
  logic              rd_sample;

  assign mem_ce   = 1'b1;
  assign mem_ad   = boot_mode ? boot_addr : cpu_addr;
  assign s_ready  = (state == ST_LOAD_ACC) || (state == ST_CSUM);
  assign rd_issue = (state == ST_VERIFY) && (rd_issued != PROG_LEN_CNT);

  boot_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue      (rd_issue),
    .sample_vld (rd_sample)
  );

  // NOTE: every register here uses <= so all updates in a cycle see the
  // pre-edge values; blocking assignments would make the order of
  // statements change the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_LOAD_ACC;
      boot_addr  <= '0;
      word_count <= '0;
      write_sum  <= '0;
      read_sum   <= '0;
      expected   <= '0;
      rd_issued  <= '0;
      rd_sampled <= '0;
      mem_wre    <= 1'b0;
      mem_din    <= '0;
      boot_mode  <= 1'b1;
      boot_done  <= 1'b0;
      boot_err   <= 1'b0;
    end else begin
      case (state)
        ST_LOAD_ACC: begin
          if (s_valid) begin
            mem_din   <= s_data;
            mem_wre   <= 1'b1;
            write_sum <= sum_next(write_sum, s_data);
            state     <= ST_LOAD_WR;
          end
        end

        ST_LOAD_WR: begin
          mem_wre    <= 1'b0;
          word_count <= word_count + CNT_ONE;
          if (word_count + CNT_ONE == PROG_LEN_CNT) begin
            boot_addr <= '0;
            state     <= ST_CSUM;
          end else begin
            boot_addr <= boot_addr + ADDR_ONE;
            state     <= ST_LOAD_ACC;
          end
        end

        // The checksum word is captured only; it never reaches the memory.
        ST_CSUM: begin
          if (s_valid) begin
            expected   <= s_data;
            boot_addr  <= '0;
            rd_issued  <= '0;
            rd_sampled <= '0;
            state      <= ST_VERIFY;
          end
        end

        ST_VERIFY: begin
          if (rd_issue) begin
            rd_issued <= rd_issued + CNT_ONE;
            if (boot_addr != LAST_ADDR) begin
              boot_addr <= boot_addr + ADDR_ONE;
            end
          end
          if (rd_sample) begin
            read_sum   <= sum_next(read_sum, mem_dout);
            rd_sampled <= rd_sampled + CNT_ONE;
            if (rd_sampled + CNT_ONE == PROG_LEN_CNT) begin
              boot_addr <= '0;
              state     <= ST_CHECK;
            end
          end
        end

        ST_CHECK: begin
          if (expected == write_sum && read_sum == write_sum) begin
            boot_mode <= 1'b0;
            boot_done <= 1'b1;
            state     <= ST_RUN;
          end else begin
            boot_err <= 1'b1;
            state    <= ST_ERROR;
          end
        end

        ST_RUN, ST_ERROR: begin
          if (boot_req) begin
            boot_mode  <= 1'b1;
            boot_done  <= 1'b0;
            boot_err   <= 1'b0;
            write_sum  <= '0;
            read_sum   <= '0;
            word_count <= '0;
            boot_addr  <= '0;
            state      <= ST_LOAD_ACC;
          end
        end

        default: state <= ST_LOAD_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Drives two boot_loader instances (RD_LAT 1 and 3) from one stream and
// checks them against BSRAM models and a checksum reference model.
module tb_boot_loader;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 11;
  localparam int PROG_LEN = 4;

  typedef logic [0:PROG_LEN-1][DATA_W-1:0] img_t;

  typedef struct {
    img_t              img;
    logic [DATA_W-1:0] csum;
    int                max_gap;
    int                req_after;
    bit                exp_done;
  } boot_vec_t;

  typedef struct {
    logic [ADDR_W-1:0] ad;
    logic [DATA_W-1:0] din;
    logic [ADDR_W:0]   wc;
    int                hs;
    logic              mode;
  } wr_obs_t;

  logic              clk;
  logic              rst_n;
  logic              boot_req;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] corrupt;

  logic              s_ready1, mem_ce1, mem_wre1, boot_mode1, boot_done1, boot_err1;
  logic [ADDR_W-1:0] mem_ad1;
  logic [DATA_W-1:0] mem_din1, mem_dout1;
  logic [ADDR_W:0]   wc1;

  logic              s_ready3, mem_ce3, mem_wre3, boot_mode3, boot_done3, boot_err3;
  logic [ADDR_W-1:0] mem_ad3;
  logic [DATA_W-1:0] mem_din3, mem_dout3;
  logic [ADDR_W:0]   wc3;

  boot_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PROG_LEN(PROG_LEN), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .boot_req(boot_req), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready1), .cpu_addr(cpu_addr), .mem_ce(mem_ce1), .mem_wre(mem_wre1),
    .mem_ad(mem_ad1), .mem_din(mem_din1), .mem_dout(mem_dout1), .boot_mode(boot_mode1),
    .boot_done(boot_done1), .boot_err(boot_err1), .word_count(wc1)
  );

  boot_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PROG_LEN(PROG_LEN), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .boot_req(boot_req), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready3), .cpu_addr(cpu_addr), .mem_ce(mem_ce3), .mem_wre(mem_wre3),
    .mem_ad(mem_ad3), .mem_din(mem_din3), .mem_dout(mem_dout3), .boot_mode(boot_mode3),
    .boot_done(boot_done3), .boot_err(boot_err3), .word_count(wc3)
  );

  // BSRAM models: read-before-write, output delayed by the read latency.
  logic [DATA_W-1:0] mem1 [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] mem3 [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] p3 [0:2];

  always @(posedge clk) begin
    if (mem_ce1) begin
      if (mem_wre1) mem1[mem_ad1] <= mem_din1;
      rd1 <= mem1[mem_ad1];
    end
    if (mem_ce3) begin
      if (mem_wre3) mem3[mem_ad3] <= mem_din3;
      p3[0] <= mem3[mem_ad3];
    end
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign mem_dout1 = rd1 ^ corrupt;
  assign mem_dout3 = p3[2] ^ corrupt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Handshake counter and write log for the RD_LAT=1 instance.
  int      hs_cnt = 0;
  wr_obs_t obs[$];

  always @(posedge clk) begin
    if (rst_n && s_valid && s_ready1) hs_cnt <= hs_cnt + 1;
  end

  always @(negedge clk) begin
    if (rst_n && mem_wre1) obs.push_back('{mem_ad1, mem_din1, wc1, hs_cnt, boot_mode1});
  end

  int n_vec = 0;
  int n_err = 0;
  int hs_base;
  int obs_base;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " mode1"}, boot_mode1, 1);
    check({tag, " done1"}, boot_done1, 0);
    check({tag, " err1"},  boot_err1, 0);
    check({tag, " wre1"},  mem_wre1, 0);
    check({tag, " ce1"},   mem_ce1, 1);
    check({tag, " din1"},  mem_din1, 0);
    check({tag, " wc1"},   wc1, 0);
    check({tag, " rdy1"},  s_ready1, 1);
    check({tag, " ad1"},   mem_ad1, 0);
    check({tag, " mode3"}, boot_mode3, 1);
    check({tag, " done3"}, boot_done3, 0);
    check({tag, " wc3"},   wc3, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_valid  = 1'b0;
    boot_req = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_req();
    boot_req = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;
  endtask

  task automatic restart(input string tag);
    pulse_req();
    check({tag, " restart mode1"}, boot_mode1, 1);
    check({tag, " restart done1"}, boot_done1, 0);
    check({tag, " restart err1"},  boot_err1, 0);
    check({tag, " restart wc1"},   wc1, 0);
    check({tag, " restart err3"},  boot_err3, 0);
    check({tag, " restart rdy3"},  s_ready3, 1);
  endtask

  task automatic send(input logic [DATA_W-1:0] w, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    s_valid = 1'b1;
    s_data  = w;
    n = 0;
    while (!s_ready1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stream ready", s_ready1, 1);
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = DATA_W'($urandom);
  endtask

  task automatic run_boot(input img_t img, input logic [DATA_W-1:0] csum, input int max_gap,
                          input int req_after, output int t_done);
    int n;
    hs_base  = hs_cnt;
    obs_base = obs.size();
    for (int k = 0; k < PROG_LEN; k++) begin
      send(img[k], int'($urandom_range(0, max_gap)));
      if (k == req_after) pulse_req();
    end
    send(csum, int'($urandom_range(0, max_gap)));
    t_done = -1;
    n = 0;
    while (n < 200) begin
      if (boot_done1 && t_done < 0) t_done = cyc;
      if ((boot_done1 || boot_err1) && (boot_done3 || boot_err3)) break;
      @(negedge clk);
      n++;
    end
    check("boot finished", (boot_done1 | boot_err1) & (boot_done3 | boot_err3), 1);
  endtask

  task automatic check_boot(input string tag, input img_t img, input bit exp_done);
    wr_obs_t o;
    check({tag, " done1"}, boot_done1, exp_done);
    check({tag, " err1"},  boot_err1, !exp_done);
    check({tag, " mode1"}, boot_mode1, !exp_done);
    check({tag, " done3"}, boot_done3, exp_done);
    check({tag, " err3"},  boot_err3, !exp_done);
    check({tag, " mode3"}, boot_mode3, !exp_done);
    check({tag, " wc1"},   wc1, PROG_LEN);
    check({tag, " wc3"},   wc3, PROG_LEN);
    check({tag, " writes"}, obs.size() - obs_base, PROG_LEN);
    for (int i = 0; i < PROG_LEN && obs_base + i < obs.size(); i++) begin
      o = obs[obs_base + i];
      check($sformatf("%s w%0d addr", tag, i), o.ad, i);
      check($sformatf("%s w%0d data", tag, i), o.din, img[i]);
      check($sformatf("%s w%0d count", tag, i), o.wc, i);
      check($sformatf("%s w%0d handshake", tag, i), o.hs, hs_base + i + 1);
      check($sformatf("%s w%0d mode", tag, i), o.mode, 1);
    end
    for (int i = 0; i < PROG_LEN; i++) begin
      check($sformatf("%s mem1[%0d]", tag, i), mem1[i], img[i]);
      check($sformatf("%s mem3[%0d]", tag, i), mem3[i], img[i]);
    end
  endtask

  boot_vec_t vecs[7];

  initial begin
    img_t              img;
    logic [DATA_W-1:0] cs;
    logic [ADDR_W-1:0] ca;
    int                t;
    int                s;
    int                n;
    int                req_after;
    bit                good;

    vecs[0] = '{img: {16'h00A1, 16'h0078, 16'h0008, 16'h0092}, csum: 16'h01B3, max_gap: 0, req_after: -1, exp_done: 1};
    vecs[1] = '{img: {16'h00A1, 16'h0078, 16'h0008, 16'h0092}, csum: 16'h01B4, max_gap: 0, req_after: -1, exp_done: 0};
    vecs[2] = '{img: {16'h00A1, 16'h0078, 16'h0008, 16'h0092}, csum: 16'h01B3, max_gap: 5, req_after: -1, exp_done: 1};
    vecs[3] = '{img: {16'h1111, 16'h2222, 16'h3333, 16'h4444}, csum: 16'hAAAA, max_gap: 0, req_after: -1, exp_done: 1};
    vecs[4] = '{img: {16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF}, csum: 16'hFFFF, max_gap: 3, req_after: -1, exp_done: 1};
    vecs[5] = '{img: {16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF}, csum: 16'h7FFF, max_gap: 1, req_after: -1, exp_done: 0};
    vecs[6] = '{img: {16'h1111, 16'h2222, 16'h3333, 16'h4444}, csum: 16'hAAAA, max_gap: 2, req_after: 1, exp_done: 1};

    rst_n    = 1'b0;
    boot_req = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    corrupt  = '0;
    cpu_addr = 11'h5A5;

    repeat (2) @(negedge clk);
    check_reset_vals("reset");

    // Table-driven boots; the first follows reset and checks exact timing.
    for (int v = 0; v < 7; v++) begin
      if (v == 0) do_reset();
      else        restart($sformatf("vec%0d", v));
      run_boot(vecs[v].img, vecs[v].csum, vecs[v].max_gap, vecs[v].req_after, t);
      check_boot($sformatf("vec%0d", v), vecs[v].img, vecs[v].exp_done);
      if (v == 0) begin
        check("done cycle", t, 15);
        for (int k = 0; k < 3; k++) begin
          ca = ADDR_W'($urandom);
          cpu_addr = ca;
          #1;
          check($sformatf("cpu addr follow %0d", k), mem_ad1, ca);
        end
        @(negedge clk);
      end
      if (!vecs[v].exp_done) begin
        cpu_addr = 11'h7FF;
        #1;
        check($sformatf("vec%0d cpu isolated", v), mem_ad1 == cpu_addr, 0);
        @(negedge clk);
      end
    end

    // Read-back corruption with a correct checksum must still fail.
    restart("readback");
    corrupt = 16'h0001;
    run_boot(vecs[0].img, vecs[0].csum, 0, -1, t);
    corrupt = '0;
    check_boot("readback", vecs[0].img, 0);

    // Reset in the middle of a load, then a fresh load from address 0.
    restart("rst_mid");
    send(16'hBEEF, 0);
    send(16'hCAFE, 0);
    n = 0;
    while (wc1 != 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid wc before reset", wc1, 2);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    run_boot(vecs[3].img, vecs[3].csum, 1, -1, t);
    check_boot("rst_mid reload", vecs[3].img, 1);

    // Random images against a plain-arithmetic checksum model.
    for (int it = 0; it < 16; it++) begin
      s = 0;
      for (int k = 0; k < PROG_LEN; k++) begin
        img[k] = DATA_W'($urandom);
        s = (s + int'(img[k])) % 65536;
      end
      good = ($urandom_range(0, 1) == 1);
      cs = good ? DATA_W'(s) : DATA_W'((s + 1 + int'($urandom_range(0, 65534))) % 65536);
      req_after = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      restart($sformatf("rand%0d", it));
      run_boot(img, cs, 5, req_after, t);
      check_boot($sformatf("rand%0d", it), img, good);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
